// File: rtl/sprite_pixel_reader.sv
// Sprite pixel reader: fetches 4-pixel sprite words through a one-word tag cache,
// selects the pixel nibble, maps it through a 16-entry palette. Fixed 3-edge latency.
module sprite_pixel_reader #(
    parameter int          MEM_LAT    = 2,
    parameter logic [3:0]  TRANSP_IDX = 4'h0
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic        playerOn,
    input  logic [20:0] spriteAddress,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        mem_re,
    output logic [18:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [23:0] pal_data,
    output logic        pixelOn,
    output logic [23:0] pixelColor,
    output logic [9:0]  DrawX_d,
    output logic [9:0]  DrawY_d,
    output logic [15:0] readsLastFrame
);

    if (MEM_LAT != 2) begin : g_unsupported_lat
        $error("sprite_pixel_reader supports MEM_LAT == 2 only");
    end

    // Request-side state
    logic [18:0] tag;
    logic        tag_valid;
    logic [15:0] read_count;

    logic [18:0] word_addr;
    logic        frame_start;
    logic        hit;
    logic        fetch;
    logic        tag_valid_d;
    logic [15:0] count_inc;

    // Pipeline stages
    logic        s1_valid, s1_on, s1_fetch;
    logic [1:0]  s1_sel;
    logic [9:0]  s1_x, s1_y;
    logic        s2_valid, s2_on, s2_fetch;
    logic [1:0]  s2_sel;
    logic [9:0]  s2_x, s2_y;
    logic        s3_valid, s3_on;
    logic [3:0]  s3_idx;
    logic [9:0]  s3_x, s3_y;

    logic [15:0] word_reg;
    logic [15:0] cur_word;
    logic [3:0]  cur_idx;
    logic        pix_visible;

    logic [23:0] palette [16];

    // Request decode
    always_comb begin
        word_addr   = spriteAddress[20:2];
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        // A frame start invalidates the tag before the compare, so it always misses
        hit         = playerOn && tag_valid && (word_addr == tag) && !frame_start;
        fetch       = playerOn && !hit;
        if (fetch) begin
            tag_valid_d = 1'b1;
        end else if (frame_start) begin
            tag_valid_d = 1'b0;
        end else begin
            tag_valid_d = tag_valid;
        end
        if (fetch && (read_count != 16'hFFFF)) begin
            count_inc = read_count + 16'd1;
        end else begin
            count_inc = read_count;
        end
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            mem_re    <= 1'b0;
            mem_addr  <= 19'd0;
            tag       <= 19'd0;
            tag_valid <= 1'b0;
        end else begin
            mem_re    <= fetch;
            tag_valid <= tag_valid_d;
            if (fetch) begin
                mem_addr <= word_addr;
                tag      <= word_addr;
            end
        end
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            read_count     <= 16'd0;
            readsLastFrame <= 16'd0;
        end else if (frame_start) begin
            readsLastFrame <= count_inc;
            read_count     <= {15'd0, fetch};
        end else begin
            read_count     <= count_inc;
        end
    end

    // Stages 1 and 2 carry the sample while the memory read is in flight
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_on    <= 1'b0;
            s1_fetch <= 1'b0;
            s1_sel   <= 2'd0;
            s1_x     <= 10'd0;
            s1_y     <= 10'd0;
            s2_valid <= 1'b0;
            s2_on    <= 1'b0;
            s2_fetch <= 1'b0;
            s2_sel   <= 2'd0;
            s2_x     <= 10'd0;
            s2_y     <= 10'd0;
        end else begin
            s1_valid <= 1'b1;
            s1_on    <= playerOn;
            s1_fetch <= fetch;
            s1_sel   <= spriteAddress[1:0];
            s1_x     <= DrawX;
            s1_y     <= DrawY;
            s2_valid <= s1_valid;
            s2_on    <= s1_on;
            s2_fetch <= s1_fetch;
            s2_sel   <= s1_sel;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
        end
    end

    // Fetched samples bypass word_reg; hits rely on it having been refreshed one edge earlier
    always_comb begin
        cur_word = (s2_valid && s2_fetch) ? mem_rdata : word_reg;
        unique case (s2_sel)
            2'd0: cur_idx = cur_word[3:0];
            2'd1: cur_idx = cur_word[7:4];
            2'd2: cur_idx = cur_word[11:8];
            2'd3: cur_idx = cur_word[15:12];
            default: cur_idx = 4'd0;
        endcase
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            word_reg <= 16'd0;
            s3_valid <= 1'b0;
            s3_on    <= 1'b0;
            s3_idx   <= 4'd0;
            s3_x     <= 10'd0;
            s3_y     <= 10'd0;
        end else begin
            if (s2_valid && s2_fetch) begin
                word_reg <= mem_rdata;
            end
            s3_valid <= s2_valid;
            s3_on    <= s2_on;
            s3_idx   <= cur_idx;
            s3_x     <= s2_x;
            s3_y     <= s2_y;
        end
    end

    always_comb begin
        pix_visible = s3_valid && s3_on && (s3_idx != TRANSP_IDX);
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            pixelOn    <= 1'b0;
            pixelColor <= 24'd0;
            DrawX_d    <= 10'd0;
            DrawY_d    <= 10'd0;
        end else begin
            pixelOn    <= pix_visible;
            pixelColor <= pix_visible ? palette[s3_idx] : 24'd0;
            DrawX_d    <= s3_x;
            DrawY_d    <= s3_y;
        end
    end

    // Same-edge write and lookup: the lookup sees the pre-write entry
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= 24'd0;
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader with a 2-edge sprite memory model.
module tb_sprite_pixel_reader;

    logic        frame_Clk;
    logic        Reset;
    logic        playerOn;
    logic [20:0] spriteAddress;
    logic [9:0]  DrawX, DrawY;
    logic        mem_re;
    logic [18:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic        pixelOn;
    logic [23:0] pixelColor;
    logic [9:0]  DrawX_d, DrawY_d;
    logic [15:0] readsLastFrame;

    logic [15:0] mem [256];
    logic [23:0] exp_col [4];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses;

    sprite_pixel_reader #(
        .MEM_LAT    (2),
        .TRANSP_IDX (4'h0)
    ) dut (
        .frame_Clk      (frame_Clk),
        .Reset          (Reset),
        .playerOn       (playerOn),
        .spriteAddress  (spriteAddress),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .mem_re         (mem_re),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_data       (pal_data),
        .pixelOn        (pixelOn),
        .pixelColor     (pixelColor),
        .DrawX_d        (DrawX_d),
        .DrawY_d        (DrawY_d),
        .readsLastFrame (readsLastFrame)
    );

    initial frame_Clk = 1'b0;
    always #5 frame_Clk = ~frame_Clk;

    // Request seen after edge k, data registered at k+1, consumed by the DUT at k+2
    always @(posedge frame_Clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge frame_Clk);
        #1;
    endtask

    task automatic drive(input logic on, input logic [20:0] a, input logic [9:0] x,
                         input logic [9:0] y);
        playerOn      = on;
        spriteAddress = a;
        DrawX         = x;
        DrawY         = y;
    endtask

    task automatic idle();
        drive(1'b0, 21'h0, 10'd1, 10'd1);
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
        tick();
        pal_we   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_pixelOn"}, 32'(pixelOn), 32'd0);
        chk({tag, "_pixelColor"}, 32'(pixelColor), 32'd0);
        chk({tag, "_DrawX_d"}, 32'(DrawX_d), 32'd0);
        chk({tag, "_DrawY_d"}, 32'(DrawY_d), 32'd0);
        chk({tag, "_readsLastFrame"}, 32'(readsLastFrame), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[16]   = 16'h0500;
        mem[17]   = 16'h1111;
        mem[18]   = 16'h0000;
        mem[19]   = 16'h5555;
        mem_rdata = 16'h0;
        Reset     = 1'b1;
        pal_we    = 1'b0;
        pal_addr  = 4'h0;
        pal_data  = 24'h0;
        drive(1'b0, 21'h0, 10'd0, 10'd0);
        repeat (3) tick();
        chk_all_zero("reset");

        Reset = 1'b0;
        idle();
        pal_write(4'h5, 24'hFF8000);
        pal_write(4'h7, 24'h0000FF);
        pal_write(4'hA, 24'h123456);
        pal_write(4'h3, 24'hABCDEF);

        // Single miss: nibble 2 of 16'h0500 is index 5
        drive(1'b1, 21'h00042, 10'd10, 10'd3);
        tick();
        chk("miss_mem_re", 32'(mem_re), 32'd1);
        chk("miss_mem_addr", 32'(mem_addr), 32'h10);
        idle();
        tick();
        chk("miss_re_drop", 32'(mem_re), 32'd0);
        tick();
        tick();
        chk("miss_pixelOn", 32'(pixelOn), 32'd1);
        chk("miss_color", 32'(pixelColor), 32'hFF8000);
        chk("miss_DrawX_d", 32'(DrawX_d), 32'd10);
        chk("miss_DrawY_d", 32'(DrawY_d), 32'd3);

        // Different word so the next burst starts with a miss
        drive(1'b1, 21'h00048, 10'd1, 10'd1);
        tick();
        idle();
        repeat (4) tick();

        // Four pixels from one word: indices 7, 5, A, 3
        mem[16]    = 16'h3A57;
        exp_col[0] = 24'h0000FF;
        exp_col[1] = 24'hFF8000;
        exp_col[2] = 24'h123456;
        exp_col[3] = 24'hABCDEF;
        pulses     = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, 21'(32'h40 + i), 10'(20 + i), 10'd2);
            else idle();
            tick();
            if (mem_re) pulses++;
            if (i >= 3 && i <= 6) begin
                chk($sformatf("burst_on_%0d", i - 3), 32'(pixelOn), 32'd1);
                chk($sformatf("burst_color_%0d", i - 3), 32'(pixelColor), 32'(exp_col[i - 3]));
                chk($sformatf("burst_x_%0d", i - 3), 32'(DrawX_d), 32'(20 + i - 3));
            end
        end
        chk("burst_pulses", 32'(pulses), 32'd1);

        // Transparent index
        drive(1'b1, 21'h00049, 10'd100, 10'd50);
        tick();
        idle();
        repeat (3) tick();
        chk("transp_pixelOn", 32'(pixelOn), 32'd0);
        chk("transp_color", 32'(pixelColor), 32'd0);
        chk("transp_DrawX_d", 32'(DrawX_d), 32'd100);
        chk("transp_DrawY_d", 32'(DrawY_d), 32'd50);

        // Palette write at the same edge as the lookup of index 5
        drive(1'b1, 21'h0004C, 10'd30, 10'd4);
        tick();
        drive(1'b1, 21'h0004D, 10'd31, 10'd4);
        tick();
        idle();
        tick();
        pal_we   = 1'b1;
        pal_addr = 4'h5;
        pal_data = 24'h00FF00;
        tick();
        pal_we   = 1'b0;
        chk("palwr_old", 32'(pixelColor), 32'hFF8000);
        tick();
        chk("palwr_new", 32'(pixelColor), 32'h00FF00);

        // Five reads so far; frame start without a fetch
        drive(1'b0, 21'h0, 10'd0, 10'd0);
        tick();
        chk("frame0_reads", 32'(readsLastFrame), 32'd5);
        for (int i = 0; i < 36; i++) begin
            drive(1'b1, (i % 2 == 0) ? 21'h40 : 21'h44, 10'd200, 10'd7);
            tick();
        end
        // Same word as the tag, but a frame start forces a fetch
        drive(1'b1, 21'h00044, 10'd0, 10'd0);
        tick();
        chk("frame1_mem_re", 32'(mem_re), 32'd1);
        chk("frame1_mem_addr", 32'(mem_addr), 32'h11);
        chk("frame1_reads", 32'(readsLastFrame), 32'd37);
        drive(1'b1, 21'h00045, 10'd5, 10'd0);
        tick();
        chk("frame1_hit_re", 32'(mem_re), 32'd0);
        chk("frame1_reads_hold", 32'(readsLastFrame), 32'd37);
        drive(1'b0, 21'h0, 10'd0, 10'd0);
        tick();
        chk("frame2_reads", 32'(readsLastFrame), 32'd1);

        // Reset one edge after a miss; palette write during reset is ignored
        drive(1'b1, 21'h00042, 10'd7, 10'd7);
        tick();
        chk("abort_mem_re", 32'(mem_re), 32'd1);
        Reset    = 1'b1;
        pal_we   = 1'b1;
        pal_addr = 4'hA;
        pal_data = 24'hABCDEF;
        idle();
        tick();
        chk_all_zero("abort_reset");
        Reset  = 1'b0;
        pal_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_no_pix_%0d", i), 32'(pixelOn), 32'd0);
        end
        drive(1'b1, 21'h00042, 10'd9, 10'd9);
        tick();
        idle();
        repeat (3) tick();
        chk("postrst_pixelOn", 32'(pixelOn), 32'd1);
        chk("postrst_color", 32'(pixelColor), 32'd0);
        chk("postrst_DrawX_d", 32'(DrawX_d), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_reader.md
SPRITE_PIXEL_READER -- requirements
Module: sprite_pixel_reader

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning sprite-memory read latency in frame_Clk edges; only 2 is supported.
REQ-002 SHALL have parameter TRANSP_IDX, default 4'h0, meaning the palette index treated as transparent.
REQ-003 SHALL have port frame_Clk, input, 1, the pixel-pipeline clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port playerOn, input, 1, the sprite-coverage flag from the animation address generator.
REQ-006 SHALL have port spriteAddress, input, 21, the sprite pixel address: [20:2] is the word address, [1:0] is the nibble select.
REQ-007 SHALL have ports DrawX and DrawY, input, 10 each, the current beam position.
REQ-008 SHALL have ports mem_re (output, 1) and mem_addr (output, 19), the registered sprite-memory read request.
REQ-009 SHALL have port mem_rdata, input, 16, holding four 4-bit palette indices; nibble n is bits [4n+3:4n].
REQ-010 SHALL have palette write ports pal_we (input, 1), pal_addr (input, 4) and pal_data (input, 24).
REQ-011 SHALL have output ports pixelOn (1) and pixelColor (24, RGB888), the decoded sprite pixel.
REQ-012 SHALL have output ports DrawX_d and DrawY_d, 10 each, holding DrawX and DrawY delayed to align with pixelOn.
REQ-013 SHALL have output port readsLastFrame, 16, the number of memory reads issued in the previous frame.

Function
REQ-014 SHALL sample playerOn, spriteAddress, DrawX and DrawY at edge k and present the matching pixelOn, pixelColor, DrawX_d and DrawY_d after edge k+3; latency is fixed, with no stalls and no bubbles.
REQ-015 SHALL keep a one-word tag register (tag, tagValid) holding the word address of the most recent request.
REQ-016 SHALL treat a sample at edge k as a hit when playerOn=1, tagValid=1 and spriteAddress[20:2]==tag.
REQ-017 On a sample at edge k with playerOn=1 that is not a hit, SHALL drive mem_re=1 and mem_addr=spriteAddress[20:2] after edge k, set tag to that address and set tagValid=1.
REQ-018 When playerOn=0, or on a hit, SHALL drive mem_re=0 after edge k and leave mem_addr unchanged.
REQ-019 SHALL carry a fetched flag down the pipeline with each sample.
REQ-020 At edge k+2, a fetched sample SHALL take its word from mem_rdata and copy it into wordReg; a hit sample SHALL take its word from wordReg.
REQ-021 Back-to-back same-word samples SHALL be served correctly: the hit at edge k+1 reads wordReg after it has been updated at edge k+2.
REQ-022 SHALL register the selected nibble at edge k+2, using nibble select spriteAddress[1:0] as delayed.
REQ-023 At edge k+3, SHALL set pixelOn=1 and pixelColor=palette[idx] when on=1 and idx!=TRANSP_IDX; otherwise SHALL set pixelOn=0 and pixelColor=24'h0.
REQ-024 SHALL hold a palette of 16 x 24-bit entries; pal_we=1 at an edge writes pal_data to palette[pal_addr].
REQ-025 A palette lookup at the same edge as a write to the same entry SHALL return the old value; later edges SHALL see the new value.
REQ-026 SHALL detect a frame start when a sample has DrawX==0 and DrawY==0.
REQ-027 On a frame start, SHALL clear tagValid, and the frame-start sample itself SHALL be treated as a miss.
REQ-028 If invalidation and a hit coincide, invalidation SHALL win and a fetch SHALL be issued.
REQ-029 SHALL count memory reads in a 16-bit readCount that saturates at 16'hFFFF.
REQ-030 On a frame start, SHALL copy readCount, including any read issued at that edge, into readsLastFrame.
REQ-031 On a frame start, SHALL restart readCount at 1 if the frame-start sample fetches, otherwise at 0.

Reset
REQ-032 While Reset=1 at an edge, SHALL clear mem_re, mem_addr, tag, tagValid, wordReg, all pipeline valid/on/fetched flags, pixelOn, pixelColor, DrawX_d, DrawY_d, readCount, readsLastFrame and all palette entries to 0.
REQ-033 A read in flight when Reset is asserted SHALL be discarded, and its returning mem_rdata SHALL be ignored.
REQ-034 After Reset is released at edge r, the first valid output SHALL appear after edge r+4 at the earliest, from a sample taken at edge r+1.
REQ-035 pal_we SHALL be ignored while Reset=1.

Verification
REQ-036 Bench SHALL set palette[5]=24'hFF8000, give the memory word 19'h00010 the value 16'h0500, and drive playerOn=1 with spriteAddress=21'h00042 at edge 0; it SHALL require mem_re=1 with mem_addr=19'h00010 after edge 0, then pixelOn=1 and pixelColor=24'hFF8000 after edge 3.
REQ-037 Bench SHALL drive addresses 21'h40, 41, 42 and 43 on consecutive edges; it SHALL require exactly one mem_re pulse and four correct colors on consecutive cycles after edges 3 through 6.
REQ-038 Bench SHALL drive a nibble equal to TRANSP_IDX (0) with playerOn=1; it SHALL require pixelOn=0 and pixelColor=0 after edge k+3, with DrawX_d still equal to the sampled DrawX.
REQ-039 Bench SHALL present a frame-start sample (DrawX=0, DrawY=0) with the same word as the tag; it SHALL require a fresh mem_re, and readsLastFrame SHALL equal the previous frame's read count (for example 37).
REQ-040 Bench SHALL assert Reset one edge after a miss request; it SHALL require all outputs to be 0 after the reset edge, no pixelOn pulse from the aborted read, and palette reads to return 0.
REQ-041 Bench SHALL write palette[5]=24'h00FF00 on the same edge that a lookup of index 5 occurs; it SHALL require the old color on that output and 24'h00FF00 on a lookup one edge later.
